// File: rtl/fgp_color_writer.sv
`default_nettype none
// ============================================================================
// Module   : fgp_color_writer
// Function : Packs the FGP payload byte stream (3 bytes -> 2 x 12-bit colors)
//            into framebuffer writes at base offset + color index.
// Revision : 1.0 - initial release
// ============================================================================
module fgp_color_writer #(
  parameter int ADDR_W    = 17,
  parameter int COLOR_W   = 12,
  parameter int RAM_DEPTH = 76800,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               inclk,
  input  logic [7:0]         in,
  input  logic               setoff_req,
  input  logic [ADDR_W-1:0]  setoff_val,
  input  logic               done,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [COLOR_W-1:0] ram_din,
  output logic               pkt_done,
  output logic               err_align,
  output logic               err_range,
  output logic [CNT_W-1:0]   pkt_cnt
);

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } phase_t;

  // One extra bit so a depth equal to 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(RAM_DEPTH);

  phase_t             phase;
  logic [7:0]         hold;
  logic [3:0]         nibble;
  logic [ADDR_W-1:0]  wr_addr;
  logic               emit;
  logic [COLOR_W-1:0] color;
  logic               in_range;

  always_comb begin
    emit  = 1'b0;
    color = '0;
    if (inclk && !setoff_req) begin
      case (phase)
        P1: begin
          emit  = 1'b1;
          color = COLOR_W'({hold, in[7:4]});
        end
        P2: begin
          emit  = 1'b1;
          color = COLOR_W'({nibble, in});
        end
        default: begin
          emit  = 1'b0;
          color = '0;
        end
      endcase
    end
  end

  assign in_range = ({1'b0, wr_addr} < DEPTH_LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase     <= P0;
      hold      <= '0;
      nibble    <= '0;
      wr_addr   <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      pkt_done  <= 1'b0;
      err_align <= 1'b0;
      err_range <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      ram_we    <= 1'b0;
      pkt_done  <= 1'b0;
      err_align <= 1'b0;
      if (setoff_req) begin
        // A byte arriving with the base load is dropped along with any partial color.
        wr_addr <= setoff_val;
        phase   <= P0;
      end else if (inclk) begin
        case (phase)
          P0: begin
            hold  <= in;
            phase <= P1;
          end
          P1: begin
            nibble <= in[3:0];
            phase  <= P2;
          end
          default: phase <= P0;
        endcase
        if (emit) begin
          ram_addr <= wr_addr;
          ram_din  <= color;
          ram_we   <= in_range;
          wr_addr  <= wr_addr + ADDR_W'(1);
          if (!in_range) begin
            err_range <= 1'b1;
          end
        end
        if (done) begin
          phase     <= P0;
          pkt_cnt   <= pkt_cnt + CNT_W'(1);
          pkt_done  <= 1'b1;
          err_align <= (phase != P2);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fgp_color_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fgp_color_writer
// Function : Self-checking bench for fgp_color_writer against a byte-stream
//            color model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fgp_color_writer;

  localparam int ADDR_W    = 17;
  localparam int COLOR_W   = 12;
  localparam int RAM_DEPTH = 76800;
  localparam int CNT_W     = 16;

  logic               clk = 1'b0;
  logic               rstn;
  logic               inclk;
  logic [7:0]         in;
  logic               setoff_req;
  logic [ADDR_W-1:0]  setoff_val;
  logic               done;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [COLOR_W-1:0] ram_din;
  logic               pkt_done;
  logic               err_align;
  logic               err_range;
  logic [CNT_W-1:0]   pkt_cnt;

  fgp_color_writer #(
    .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .RAM_DEPTH(RAM_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .inclk(inclk), .in(in),
    .setoff_req(setoff_req), .setoff_val(setoff_val), .done(done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .pkt_done(pkt_done), .err_align(err_align), .err_range(err_range),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  wr_t        obs_q[$];
  wr_t        exp_q[$];
  logic [7:0] pkt[$];
  int pd_cnt, ea_cnt, pd_last_cyc, wr_last_cyc;
  int m_cnt = 0;
  bit m_err_range = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      obs_q.push_back('{int'(ram_addr), int'(ram_din)});
      wr_last_cyc = cyc;
    end
    if (pkt_done === 1'b1) begin
      pd_cnt++;
      pd_last_cyc = cyc;
    end
    if (err_align === 1'b1) ea_cnt++;
  end

  // Expected writes from the packet bytes: every 3 bytes give two colors,
  // a trailing 2-byte group gives one, a trailing single byte gives none.
  function automatic void build_expected(input int base);
    int ncol;
    ncol = (pkt.size() / 3) * 2 + (((pkt.size() % 3) == 2) ? 1 : 0);
    exp_q.delete();
    for (int k = 0; k < ncol; k++) begin
      int j, addr, c;
      j    = 3 * (k / 2);
      addr = (base + k) % (1 << ADDR_W);
      if (k % 2 == 0) c = (int'(pkt[j]) << 4) | (int'(pkt[j+1]) >> 4);
      else            c = ((int'(pkt[j+1]) & 15) << 8) | int'(pkt[j+2]);
      if (addr < RAM_DEPTH) exp_q.push_back('{addr, c});
      else m_err_range = 1'b1;
    end
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (exp_q[i].addr != obs_q[i].addr || exp_q[i].data != obs_q[i].data) return i;
    return -1;
  endfunction

  task automatic drive(input bit so, input int sv, input bit ic, input logic [7:0] b, input bit d);
    @(negedge clk);
    setoff_req = so;
    setoff_val = ADDR_W'(sv);
    inclk      = ic;
    in         = b;
    done       = d;
  endtask

  task automatic run_packet(input int base, input int n, input bit gaps, input bit do_set);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    obs_q.delete();
    pd_cnt = 0;
    ea_cnt = 0;
    if (do_set) drive(1'b1, base, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) drive(1'b0, 0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 0, 1'b1, pkt[i], i == n - 1);
    end
    repeat (3) drive(1'b0, 0, 1'b0, 8'h00, 1'b0);
    build_expected(base);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++; if (ram_we !== 1'b0)      begin fails++; $display("FAIL reset_we got %b expected 0", ram_we); end
    tests++; if (ram_addr !== '0)      begin fails++; $display("FAIL reset_addr got %0d expected 0", ram_addr); end
    tests++; if (ram_din !== '0)       begin fails++; $display("FAIL reset_din got %0h expected 0", ram_din); end
    tests++; if (pkt_done !== 1'b0)    begin fails++; $display("FAIL reset_pkt_done got %b expected 0", pkt_done); end
    tests++; if (err_align !== 1'b0)   begin fails++; $display("FAIL reset_err_align got %b expected 0", err_align); end
    tests++; if (err_range !== 1'b0)   begin fails++; $display("FAIL reset_err_range got %b expected 0", err_range); end
    tests++; if (pkt_cnt !== '0)       begin fails++; $display("FAIL reset_pkt_cnt got %0d expected 0", pkt_cnt); end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b1, 1536, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 0, 1'b1, 8'hAB, 1'b0);
    @(negedge clk);
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL basic_p0_no_write got %b expected 0", ram_we); end
    in = 8'hCD;
    @(negedge clk);
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 17'd1536 || ram_din !== 12'hABC) begin
      fails++; $display("FAIL basic_first got we=%b a=%0d d=%h expected we=1 a=1536 d=abc", ram_we, ram_addr, ram_din);
    end
    in = 8'hEF;
    @(negedge clk);
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 17'd1537 || ram_din !== 12'hDEF) begin
      fails++; $display("FAIL basic_second got we=%b a=%0d d=%h expected we=1 a=1537 d=def", ram_we, ram_addr, ram_din);
    end
    inclk = 1'b0;
    @(negedge clk);
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL basic_idle_we got %b expected 0", ram_we); end
  endtask

  task automatic test_full_packet(input int base, input bit gaps);
    int d;
    run_packet(base, 768, gaps, 1'b1);
    d = first_diff();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL full_count base=%0d got %0d expected %0d", base, obs_q.size(), exp_q.size()); end
    tests++;
    if (d >= 0) begin
      fails++; $display("FAIL full_data base=%0d idx=%0d got a=%0d d=%h expected a=%0d d=%h", base, d, obs_q[d].addr, obs_q[d].data, exp_q[d].addr, exp_q[d].data);
    end
    tests++; if (pd_cnt != 1) begin fails++; $display("FAIL full_pkt_done base=%0d got %0d pulses expected 1", base, pd_cnt); end
    if (exp_q.size() > 0) begin
      tests++; if (pd_last_cyc != wr_last_cyc) begin fails++; $display("FAIL full_done_align got cycle %0d expected %0d", pd_last_cyc, wr_last_cyc); end
    end
    tests++; if (ea_cnt != 0) begin fails++; $display("FAIL full_err_align got %0d pulses expected 0", ea_cnt); end
    tests++; if (err_range !== m_err_range) begin fails++; $display("FAIL full_err_range got %b expected %b", err_range, m_err_range); end
    tests++; if (pkt_cnt !== CNT_W'(m_cnt)) begin fails++; $display("FAIL full_pkt_cnt got %0d expected %0d", pkt_cnt, m_cnt); end
  endtask

  task automatic test_range();
    test_full_packet(149 * 512, 1'b0);
    tests++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1].addr != 76799) begin fails++; $display("FAIL range_last_addr got size %0d expected last 76799", obs_q.size()); end
    tests++; if (err_range !== 1'b0) begin fails++; $display("FAIL range_edge_err got %b expected 0", err_range); end
    test_full_packet(150 * 512, 1'b0);
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL range_suppress got %0d writes expected 0", obs_q.size()); end
    tests++; if (err_range !== 1'b1) begin fails++; $display("FAIL range_sticky_set got %b expected 1", err_range); end
    test_full_packet(10 * 512, 1'b0);
    tests++; if (err_range !== 1'b1) begin fails++; $display("FAIL range_sticky_hold got %b expected 1", err_range); end
  endtask

  task automatic test_misaligned();
    int d;
    run_packet(20 * 512, 767, 1'b0, 1'b1);
    d = first_diff();
    tests++; if (obs_q.size() != 511) begin fails++; $display("FAIL mis_count got %0d expected 511", obs_q.size()); end
    tests++; if (d >= 0) begin fails++; $display("FAIL mis_data idx=%0d got %h expected %h", d, obs_q[d].data, exp_q[d].data); end
    tests++; if (ea_cnt != 1) begin fails++; $display("FAIL mis_err_align got %0d pulses expected 1", ea_cnt); end
    tests++; if (pd_cnt != 1) begin fails++; $display("FAIL mis_pkt_done got %0d pulses expected 1", pd_cnt); end
    test_full_packet(21 * 512, 1'b0);
  endtask

  task automatic test_setoff_mid();
    run_packet(4 * 512, 4, 1'b0, 1'b1);
    obs_q.delete();
    drive(1'b1, 8 * 512, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 0, 1'b1, 8'h12, 1'b0);
    drive(1'b0, 0, 1'b1, 8'h34, 1'b0);
    drive(1'b0, 0, 1'b1, 8'h56, 1'b0);
    // Base load and a byte in the same cycle: the byte must be dropped.
    drive(1'b1, 9 * 512, 1'b1, 8'hFF, 1'b0);
    drive(1'b0, 0, 1'b1, 8'h78, 1'b0);
    drive(1'b0, 0, 1'b1, 8'h9A, 1'b0);
    drive(1'b0, 0, 1'b1, 8'hBC, 1'b0);
    repeat (3) drive(1'b0, 0, 1'b0, 8'h00, 1'b0);
    tests++; if (obs_q.size() != 4) begin fails++; $display("FAIL setoff_count got %0d expected 4", obs_q.size()); end
    else begin
      tests++; if (obs_q[0].addr != 4096 || obs_q[0].data != 'h123) begin fails++; $display("FAIL setoff_w0 got a=%0d d=%h expected a=4096 d=123", obs_q[0].addr, obs_q[0].data); end
      tests++; if (obs_q[1].addr != 4097 || obs_q[1].data != 'h456) begin fails++; $display("FAIL setoff_w1 got a=%0d d=%h expected a=4097 d=456", obs_q[1].addr, obs_q[1].data); end
      tests++; if (obs_q[2].addr != 4608 || obs_q[2].data != 'h789) begin fails++; $display("FAIL setoff_same_cycle got a=%0d d=%h expected a=4608 d=789", obs_q[2].addr, obs_q[2].data); end
      tests++; if (obs_q[3].addr != 4609 || obs_q[3].data != 'hABC) begin fails++; $display("FAIL setoff_w3 got a=%0d d=%h expected a=4609 d=abc", obs_q[3].addr, obs_q[3].data); end
    end
  endtask

  task automatic test_done_no_inclk();
    pd_cnt = 0;
    repeat (3) drive(1'b0, 0, 1'b0, 8'h55, 1'b1);
    repeat (2) drive(1'b0, 0, 1'b0, 8'h00, 1'b0);
    tests++; if (pkt_cnt !== CNT_W'(m_cnt)) begin fails++; $display("FAIL done_ignored_cnt got %0d expected %0d", pkt_cnt, m_cnt); end
    tests++; if (pd_cnt != 0) begin fails++; $display("FAIL done_ignored_pulse got %0d expected 0", pd_cnt); end
  endtask

  task automatic test_async_reset();
    int d;
    drive(1'b1, 16 * 512, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b1, 8'(i * 37 + 1), 1'b0);
    @(negedge clk);
    tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL areset_pre_we got %b expected 1", ram_we); end
    #2 rstn = 1'b0;
    inclk = 1'b0;
    #1;
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL areset_we got %b expected 0", ram_we); end
    tests++; if (pkt_cnt !== '0) begin fails++; $display("FAIL areset_pkt_cnt got %0d expected 0", pkt_cnt); end
    tests++; if (err_range !== 1'b0) begin fails++; $display("FAIL areset_err_range got %b expected 0", err_range); end
    m_cnt = 0;
    m_err_range = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_packet(0, 768, 1'b0, 1'b0);
    d = first_diff();
    tests++; if (obs_q.size() != 512 || d >= 0) begin fails++; $display("FAIL areset_restart got %0d writes diff at %0d expected 512 writes diff at -1", obs_q.size(), d); end
    tests++; if (pkt_cnt !== CNT_W'(m_cnt)) begin fails++; $display("FAIL areset_pkt_cnt_after got %0d expected %0d", pkt_cnt, m_cnt); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int base, n, d, ea_exp;
      base   = int'($urandom_range(0, 160)) * 512;
      n      = ($urandom_range(0, 1) == 0) ? 768 : int'($urandom_range(1, 767));
      ea_exp = (n % 3 != 0) ? 1 : 0;
      run_packet(base, n, 1'b1, 1'b1);
      d = first_diff();
      tests++;
      if (obs_q.size() != exp_q.size() || d >= 0) begin
        fails++; $display("FAIL rand_writes base=%0d n=%0d got %0d writes diff at %0d expected %0d writes", base, n, obs_q.size(), d, exp_q.size());
      end
      tests++; if (ea_cnt != ea_exp) begin fails++; $display("FAIL rand_err_align n=%0d got %0d expected %0d", n, ea_cnt, ea_exp); end
      tests++; if (pd_cnt != 1) begin fails++; $display("FAIL rand_pkt_done got %0d expected 1", pd_cnt); end
      tests++; if (err_range !== m_err_range) begin fails++; $display("FAIL rand_err_range got %b expected %b", err_range, m_err_range); end
      tests++; if (pkt_cnt !== CNT_W'(m_cnt)) begin fails++; $display("FAIL rand_pkt_cnt got %0d expected %0d", pkt_cnt, m_cnt); end
    end
  endtask

  initial begin
    rstn       = 1'b0;
    inclk      = 1'b0;
    in         = 8'h00;
    setoff_req = 1'b0;
    setoff_val = '0;
    done       = 1'b0;
    test_reset();
    test_basic();
    test_full_packet(3 * 512, 1'b0);
    test_range();
    test_misaligned();
    test_setoff_mid();
    test_done_no_inclk();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
